// File: rtl/led_seq_pkg.sv
// Shared encodings for the status-LED sequencer: colour codes, win-detect codes
// and the controller state enum.
package led_seq_pkg;

  localparam logic [1:0] COL_OFF   = 2'b00;
  localparam logic [1:0] COL_RED   = 2'b01;
  localparam logic [1:0] COL_GREEN = 2'b10;
  localparam logic [1:0] COL_BLUE  = 2'b11;

  localparam logic [1:0] DW_NONE = 2'b00;
  localparam logic [1:0] DW_P1   = 2'b01;
  localparam logic [1:0] DW_P2   = 2'b10;
  localparam logic [1:0] DW_DRAW = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    TURN,
    WIN_BLINK,
    WIN_HOLD,
    DRAW_CYCLE
  } state_t;

  // Draw animation walks red -> green -> blue -> red and never shows off.
  function automatic logic [1:0] next_draw_colour(input logic [1:0] c);
    case (c)
      COL_RED:   next_draw_colour = COL_GREEN;
      COL_GREEN: next_draw_colour = COL_BLUE;
      default:   next_draw_colour = COL_RED;
    endcase
  endfunction

endpackage

// File: rtl/led_status_sequencer_tick_prescaler.sv
// Free-running animation tick divider; restart realigns it so the first tick
// lands exactly TICK_DIV cycles later.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/led_status_sequencer.sv
// Board status-LED controller: maps game events to the RGB driver colour code
// and owns all blink/cycle timing.
module led_status_sequencer
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int BLINK_COUNT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       game_active,
  input  logic       turn,
  input  logic [1:0] detect_win,
  input  logic       clear,
  output logic [1:0] color_sel,
  output logic       busy,
  output logic       result_shown
);

  localparam int BW = $clog2(BLINK_COUNT + 1);

  state_t        state, state_next;
  logic [1:0]    winner, winner_next;
  logic [1:0]    color_next;
  logic [BW-1:0] blink_cnt, blink_cnt_next;
  logic          busy_next, shown_next;
  logic          tick, restart;

  assign restart = (state_next != state);

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (restart),
    .tick    (tick)
  );

  // The registered colour doubles as the blink phase and the draw-cycle position.
  always_comb begin
    state_next     = state;
    winner_next    = winner;
    blink_cnt_next = blink_cnt;
    color_next     = color_sel;
    if (clear) begin
      state_next = IDLE;
      color_next = COL_OFF;
    end else begin
      case (state)
        IDLE: begin
          color_next = COL_OFF;
          if (game_active) begin
            state_next = TURN;
            color_next = turn ? COL_GREEN : COL_RED;
          end
        end
        TURN: begin
          color_next = turn ? COL_GREEN : COL_RED;
          if (detect_win == DW_P1 || detect_win == DW_P2) begin
            state_next     = WIN_BLINK;
            winner_next    = detect_win;
            blink_cnt_next = '0;
            color_next     = detect_win;
          end else if (detect_win == DW_DRAW) begin
            state_next = DRAW_CYCLE;
            color_next = COL_RED;
          end else if (!game_active) begin
            state_next = IDLE;
            color_next = COL_OFF;
          end
        end
        WIN_BLINK: begin
          if (tick) begin
            blink_cnt_next = blink_cnt + BW'(1);
            if (blink_cnt_next == BW'(BLINK_COUNT)) begin
              state_next = WIN_HOLD;
              color_next = winner;
            end else begin
              color_next = (color_sel == COL_OFF) ? winner : COL_OFF;
            end
          end
        end
        WIN_HOLD: begin
          color_next = winner;
        end
        DRAW_CYCLE: begin
          if (tick) begin
            color_next = next_draw_colour(color_sel);
          end
        end
        default: begin
          state_next = IDLE;
          color_next = COL_OFF;
        end
      endcase
    end
    busy_next  = (state_next == WIN_BLINK) || (state_next == DRAW_CYCLE);
    shown_next = (state_next == WIN_HOLD) && (state != WIN_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      winner       <= COL_OFF;
      blink_cnt    <= '0;
      color_sel    <= COL_OFF;
      busy         <= 1'b0;
      result_shown <= 1'b0;
    end else begin
      state        <= state_next;
      winner       <= winner_next;
      blink_cnt    <= blink_cnt_next;
      color_sel    <= color_next;
      busy         <= busy_next;
      result_shown <= shown_next;
    end
  end

endmodule

// File: tb/tb_led_status_sequencer.sv
// Scoreboard bench for led_status_sequencer: stimulus queues expected outputs
// tagged with the clock edge they belong to; a negedge monitor checks them.
module tb_led_status_sequencer;
  import led_seq_pkg::*;

  localparam int TICK_DIV    = 4;
  localparam int BLINK_COUNT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       game_active;
  logic       turn;
  logic [1:0] detect_win;
  logic       clear;
  logic [1:0] color_sel;
  logic       busy;
  logic       result_shown;

  int cyc        = 0;
  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int         at;
    logic [1:0] col;
    logic       busy;
    logic       shown;
    string      name;
  } exp_t;

  exp_t sb[$];

  led_status_sequencer #(
    .TICK_DIV    (TICK_DIV),
    .BLINK_COUNT (BLINK_COUNT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .game_active  (game_active),
    .turn         (turn),
    .detect_win   (detect_win),
    .clear        (clear),
    .color_sel    (color_sel),
    .busy         (busy),
    .result_shown (result_shown)
  );

  always #5 clk = ~clk;

  // Edge counter: value k means k rising edges have occurred.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [1:0] col,
                             input logic b, input logic s);
    compared++;
    if (color_sel !== col || busy !== b || result_shown !== s) begin
      mismatched++;
      $display("[TB] FAIL %s: got color_sel=%b busy=%b result_shown=%b, expected color_sel=%b busy=%b result_shown=%b",
               name, color_sel, busy, result_shown, col, b, s);
    end
  endtask

  // Queue an expectation for the outputs seen after edge (now + offset).
  task automatic expectAt(input int offset, input logic [1:0] col, input logic b,
                          input logic s, input string name);
    exp_t e;
    int   pos;
    e.at    = cyc + offset;
    e.col   = col;
    e.busy  = b;
    e.shown = s;
    e.name  = name;
    pos     = sb.size();
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].at > e.at) begin
        pos = i;
        break;
      end
    end
    sb.insert(pos, e);
  endtask

  task automatic applyStimulus(input logic ga, input logic t, input logic [1:0] dw,
                               input logic clr);
    game_active = ga;
    turn        = t;
    detect_win  = dw;
    clear       = clr;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.at < cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: expectation for edge %0d missed, now at edge %0d", e.name, e.at, cyc);
      end else begin
        checkOutput(e.name, e.col, e.busy, e.shown);
      end
    end
  end

  initial begin
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, DW_NONE, 1'b0);
    #12;
    checkOutput("reset_state", COL_OFF, 1'b0, 1'b0);
    step(1);
    rst = 1'b0;
    step(1);

    // Turn colour tracking
    applyStimulus(1'b1, 1'b0, DW_NONE, 1'b0);
    expectAt(1, COL_RED, 1'b0, 1'b0, "idle_to_turn_p1");
    step(1);
    applyStimulus(1'b1, 1'b1, DW_NONE, 1'b0);
    expectAt(1, COL_GREEN, 1'b0, 1'b0, "turn_p2");
    step(1);
    applyStimulus(1'b1, 1'b0, DW_NONE, 1'b0);
    expectAt(1, COL_RED, 1'b0, 1'b0, "turn_back_p1");
    step(1);

    // Player 1 win: four 4-cycle blink phases, then hold
    applyStimulus(1'b1, 1'b0, DW_P1, 1'b0);
    expectAt(1,  COL_RED, 1'b1, 1'b0, "blink_entry");
    expectAt(4,  COL_RED, 1'b1, 1'b0, "blink_first_phase_end");
    expectAt(5,  COL_OFF, 1'b1, 1'b0, "blink_off_1");
    expectAt(9,  COL_RED, 1'b1, 1'b0, "blink_on_2");
    expectAt(13, COL_OFF, 1'b1, 1'b0, "blink_off_3");
    expectAt(16, COL_OFF, 1'b1, 1'b0, "blink_last_off");
    expectAt(17, COL_RED, 1'b0, 1'b1, "hold_entry");
    expectAt(18, COL_RED, 1'b0, 1'b0, "shown_one_cycle");
    expectAt(30, COL_RED, 1'b0, 1'b0, "hold_steady");
    step(1);
    applyStimulus(1'b1, 1'b0, DW_P2, 1'b0);
    step(6);
    applyStimulus(1'b0, 1'b0, DW_NONE, 1'b0);
    step(24);
    applyStimulus(1'b0, 1'b0, DW_NONE, 1'b1);
    expectAt(1, COL_OFF, 1'b0, 1'b0, "clear_from_hold");
    step(1);
    applyStimulus(1'b0, 1'b0, DW_NONE, 1'b0);
    expectAt(1, COL_OFF, 1'b0, 1'b0, "idle_stays");
    step(1);

    // Draw colour cycling
    applyStimulus(1'b1, 1'b0, DW_NONE, 1'b0);
    expectAt(1, COL_RED, 1'b0, 1'b0, "turn_before_draw");
    step(1);
    applyStimulus(1'b1, 1'b0, DW_DRAW, 1'b0);
    expectAt(1,  COL_RED,   1'b1, 1'b0, "draw_entry");
    expectAt(4,  COL_RED,   1'b1, 1'b0, "draw_first_phase_end");
    expectAt(5,  COL_GREEN, 1'b1, 1'b0, "draw_green");
    expectAt(9,  COL_BLUE,  1'b1, 1'b0, "draw_blue");
    expectAt(13, COL_RED,   1'b1, 1'b0, "draw_wrap");
    expectAt(17, COL_GREEN, 1'b1, 1'b0, "draw_green_again");
    step(1);
    applyStimulus(1'b1, 1'b0, DW_NONE, 1'b0);
    step(17);
    applyStimulus(1'b1, 1'b0, DW_NONE, 1'b1);
    expectAt(1, COL_OFF, 1'b0, 1'b0, "clear_from_draw");
    step(1);
    applyStimulus(1'b1, 1'b1, DW_NONE, 1'b0);
    expectAt(1, COL_GREEN, 1'b0, 1'b0, "turn_after_clear");
    step(1);

    // clear beats a simultaneous win
    applyStimulus(1'b1, 1'b1, DW_P2, 1'b1);
    expectAt(1, COL_OFF, 1'b0, 1'b0, "clear_beats_win");
    step(1);
    applyStimulus(1'b0, 1'b1, DW_NONE, 1'b0);
    expectAt(1, COL_OFF, 1'b0, 1'b0, "idle_no_blink");
    expectAt(5, COL_OFF, 1'b0, 1'b0, "still_no_blink");
    step(6);

    // Async reset in the middle of a blink, then a fresh animation
    applyStimulus(1'b1, 1'b0, DW_NONE, 1'b0);
    expectAt(1, COL_RED, 1'b0, 1'b0, "turn_p1_again");
    step(1);
    applyStimulus(1'b1, 1'b0, DW_P2, 1'b0);
    expectAt(1, COL_GREEN, 1'b1, 1'b0, "blink_p2_entry");
    step(1);
    applyStimulus(1'b0, 1'b0, DW_NONE, 1'b0);
    step(5);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset", COL_OFF, 1'b0, 1'b0);
    step(2);
    rst = 1'b0;
    step(1);
    applyStimulus(1'b1, 1'b0, DW_NONE, 1'b0);
    expectAt(1, COL_RED, 1'b0, 1'b0, "turn_after_reset");
    step(1);
    applyStimulus(1'b1, 1'b0, DW_P1, 1'b0);
    expectAt(1, COL_RED, 1'b1, 1'b0, "restart_blink_entry");
    expectAt(4, COL_RED, 1'b1, 1'b0, "restart_full_phase");
    expectAt(5, COL_OFF, 1'b1, 1'b0, "restart_first_toggle");
    step(1);
    applyStimulus(1'b1, 1'b0, DW_NONE, 1'b0);
    step(6);

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
